// File: rtl/mem_arb.sv
// Memory arbiter: a fetch port and a load/store port share one byte-wide
// synchronous RAM. Multi-byte accesses are serialised one byte per cycle.
// The arbiter grants round-robin when both ports request in the same cycle.
module mem_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        rst_c,
    input  logic        rdy,
    input  logic        if_en_i,
    input  logic [31:0] if_addr_i,
    output logic        if_done_o,
    output logic [31:0] if_data_o,
    input  logic        ls_en_i,
    input  logic        ls_we_i,
    input  logic [31:0] ls_addr_i,
    input  logic [1:0]  ls_len_i,
    input  logic [31:0] ls_data_i,
    output logic        ls_done_o,
    output logic [31:0] ls_data_o,
    output logic [31:0] mem_a_o,
    output logic        mem_wr_o,
    output logic [7:0]  mem_dout_o,
    input  logic [7:0]  mem_din_i
);
    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {GRANT_IF, GRANT_LS} grant_t;

    state_t      state, next_state;
    grant_t      last_grant, next_last_grant;
    grant_t      owner, next_owner;
    logic        is_write, next_is_write;
    logic [31:0] base, next_base;
    logic [2:0]  len, next_len;
    logic [2:0]  cnt, next_cnt;
    logic [31:0] wbuf, next_wbuf;
    logic [31:0] acc, next_acc;
    logic        if_done, next_if_done;
    logic        ls_done, next_ls_done;
    logic [31:0] if_data, next_if_data;
    logic [31:0] ls_data, next_ls_data;
    logic [31:0] addr_reg, next_addr_reg;
    logic        wr_reg, next_wr_reg;
    logic [7:0]  dout_reg, next_dout_reg;

    logic [2:0]  step;
    logic [2:0]  idx;
    logic [2:0]  req_len;
    logic [7:0]  wbyte;
    logic [31:0] acc_ins;
    logic        if_ok, ls_ok, pick_ls;

    // Datapath helpers: edge index, byte lane selection and arbitration inputs
    always_comb begin
        step    = cnt + 3'd1;
        idx     = step - 3'd2;
        if_ok   = if_en_i & ~if_done;
        ls_ok   = ls_en_i & ~ls_done;
        pick_ls = ls_ok & (~if_ok | (last_grant == GRANT_IF));
        case (ls_len_i)
            2'b00:   req_len = 3'd1;
            2'b01:   req_len = 3'd2;
            default: req_len = 3'd4;
        endcase
        case (step[1:0])
            2'd0:    wbyte = wbuf[7:0];
            2'd1:    wbyte = wbuf[15:8];
            2'd2:    wbyte = wbuf[23:16];
            default: wbyte = wbuf[31:24];
        endcase
        case (idx)
            3'd0:    acc_ins = {acc[31:8], mem_din_i};
            3'd1:    acc_ins = {acc[31:16], mem_din_i, acc[7:0]};
            3'd2:    acc_ins = {acc[31:24], mem_din_i, acc[15:0]};
            3'd3:    acc_ins = {mem_din_i, acc[23:0]};
            default: acc_ins = acc;
        endcase
    end

    // Next-state logic: accept/arbitrate in IDLE, step through bytes in BUSY
    always_comb begin
        next_state      = state;
        next_last_grant = last_grant;
        next_owner      = owner;
        next_is_write   = is_write;
        next_base       = base;
        next_len        = len;
        next_cnt        = cnt;
        next_wbuf       = wbuf;
        next_acc        = acc;
        next_if_done    = 1'b0;
        next_ls_done    = 1'b0;
        next_if_data    = if_data;
        next_ls_data    = ls_data;
        next_addr_reg   = addr_reg;
        next_wr_reg     = 1'b0;
        next_dout_reg   = dout_reg;

        case (state)
            IDLE: begin
                next_addr_reg = 32'h0;
                if (!rst_c && (if_ok || ls_ok)) begin
                    next_state = BUSY;
                    next_cnt   = 3'd0;
                    next_acc   = 32'h0;
                    if (pick_ls) begin
                        next_last_grant = GRANT_LS;
                        next_owner      = GRANT_LS;
                        next_is_write   = ls_we_i;
                        next_base       = ls_addr_i;
                        next_len        = req_len;
                        next_wbuf       = ls_data_i;
                        next_addr_reg   = ls_addr_i;
                        next_wr_reg     = ls_we_i;
                        if (ls_we_i) begin
                            next_dout_reg = ls_data_i[7:0];
                        end
                    end else begin
                        next_last_grant = GRANT_IF;
                        next_owner      = GRANT_IF;
                        next_is_write   = 1'b0;
                        next_base       = if_addr_i;
                        next_len        = 3'd4;
                        next_addr_reg   = if_addr_i;
                    end
                end
            end
            BUSY: begin
                next_cnt = step;
                if (is_write) begin
                    if (step == len) begin
                        next_state    = IDLE;
                        next_ls_done  = 1'b1;
                        next_addr_reg = 32'h0;
                    end else begin
                        next_addr_reg = base + {29'h0, step};
                        next_dout_reg = wbyte;
                        next_wr_reg   = 1'b1;
                    end
                end else if (rst_c) begin
                    next_state    = IDLE;
                    next_addr_reg = 32'h0;
                end else begin
                    if (step < len) begin
                        next_addr_reg = base + {29'h0, step};
                    end
                    if (step >= 3'd2) begin
                        next_acc = acc_ins;
                    end
                    if (step == len + 3'd1) begin
                        next_state    = IDLE;
                        next_addr_reg = 32'h0;
                        if (owner == GRANT_IF) begin
                            next_if_done = 1'b1;
                            next_if_data = acc_ins;
                        end else begin
                            next_ls_done = 1'b1;
                            next_ls_data = acc_ins;
                        end
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register: reset wins over everything, rdy low freezes all state
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_IF;
            owner      <= GRANT_IF;
            is_write   <= 1'b0;
            base       <= 32'h0;
            len        <= 3'd0;
            cnt        <= 3'd0;
            wbuf       <= 32'h0;
            acc        <= 32'h0;
            if_done    <= 1'b0;
            ls_done    <= 1'b0;
            if_data    <= 32'h0;
            ls_data    <= 32'h0;
            addr_reg   <= 32'h0;
            wr_reg     <= 1'b0;
            dout_reg   <= 8'h0;
        end else if (rdy) begin
            state      <= next_state;
            last_grant <= next_last_grant;
            owner      <= next_owner;
            is_write   <= next_is_write;
            base       <= next_base;
            len        <= next_len;
            cnt        <= next_cnt;
            wbuf       <= next_wbuf;
            acc        <= next_acc;
            if_done    <= next_if_done;
            ls_done    <= next_ls_done;
            if_data    <= next_if_data;
            ls_data    <= next_ls_data;
            addr_reg   <= next_addr_reg;
            wr_reg     <= next_wr_reg;
            dout_reg   <= next_dout_reg;
        end
    end

    assign if_done_o  = if_done;
    assign ls_done_o  = ls_done;
    assign if_data_o  = if_data;
    assign ls_data_o  = ls_data;
    assign mem_a_o    = addr_reg;
    assign mem_wr_o   = wr_reg & rdy;
    assign mem_dout_o = dout_reg;
endmodule

// File: tb/tb_mem_arb.sv
// Testbench for mem_arb: byte RAM model, directed scenarios and random traffic
// checked against a transaction-level reference memory.
module tb_mem_arb;
    logic        clk = 1'b0;
    logic        rst, rst_c, rdy;
    logic        if_en;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_en, ls_we;
    logic [31:0] ls_addr;
    logic [1:0]  ls_len;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;

    int checks = 0;
    int failures = 0;
    int wr_count = 0;
    logic [31:0] exp_if_data;
    logic [31:0] exp_ls_data;

    logic [7:0] ram [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    mem_arb dut (
        .clk(clk), .rst(rst), .rst_c(rst_c), .rdy(rdy),
        .if_en_i(if_en), .if_addr_i(if_addr), .if_done_o(if_done), .if_data_o(if_data),
        .ls_en_i(ls_en), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_len_i(ls_len),
        .ls_data_i(ls_wdata), .ls_done_o(ls_done), .ls_data_o(ls_rdata),
        .mem_a_o(mem_a), .mem_wr_o(mem_wr), .mem_dout_o(mem_dout), .mem_din_i(mem_din)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h11;
            32'h101: return 8'h22;
            32'h102: return 8'h33;
            32'h103: return 8'h44;
            32'h200: return 8'hAA;
            32'h201: return 8'hBB;
            default: return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [7:0] ram_read(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic int len_bytes(input logic [1:0] l);
        return (l == 2'b00) ? 1 : (l == 2'b01) ? 2 : 4;
    endfunction

    // Synchronous byte RAM: data appears the edge after the address
    always @(posedge clk) begin
        mem_din <= ram_read(mem_a);
        if (mem_wr === 1'b1) begin
            ram[mem_a] = mem_dout;
            wr_count++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single read transaction with per-edge address and completion timing checks
    task automatic applyRead(input bit is_if, input logic [31:0] addr, input logic [1:0] len);
        int n;
        logic [31:0] exp;
        n   = is_if ? 4 : len_bytes(len);
        exp = 32'h0;
        for (int i = 0; i < n; i++) exp[8*i +: 8] = ref_read(addr + i);
        if (is_if) begin
            if_en = 1'b1; if_addr = addr;
        end else begin
            ls_en = 1'b1; ls_we = 1'b0; ls_addr = addr; ls_len = len; ls_wdata = $urandom;
        end
        for (int k = 0; k <= n + 1; k++) begin
            tick();
            if (k < n) checkOutput("rd_addr", mem_a, addr + k);
            checkOutput("rd_done", is_if ? {31'h0, if_done} : {31'h0, ls_done}, {31'h0, k == n + 1});
        end
        if (is_if) begin
            exp_if_data = exp;
            checkOutput("rd_if_data", if_data, exp_if_data);
            if_en = 1'b0;
        end else begin
            exp_ls_data = exp;
            checkOutput("rd_ls_data", ls_rdata, exp_ls_data);
            ls_en = 1'b0;
        end
        tick();
        checkOutput("rd_done_pulse", {30'h0, if_done, ls_done}, 32'h0);
        checkOutput("rd_idle_addr", mem_a, 32'h0);
        checkOutput("rd_hold", is_if ? if_data : ls_rdata, exp);
    endtask

    // Store transaction with optional rdy stall after edge stall_at and rst_c at edge rstc_at
    task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] len, input logic [31:0] data,
                                 input int stall_at, input int rstc_at);
        int n, wc0;
        n   = len_bytes(len);
        wc0 = wr_count;
        ls_en = 1'b1; ls_we = 1'b1; ls_addr = addr; ls_len = len; ls_wdata = data;
        for (int k = 0; k <= n; k++) begin
            tick();
            if (k < n) begin
                checkOutput("wr_addr", mem_a, addr + k);
                checkOutput("wr_strobe", {31'h0, mem_wr}, 32'h1);
                checkOutput("wr_byte", {24'h0, mem_dout}, {24'h0, data[8*k +: 8]});
                checkOutput("wr_done_early", {31'h0, ls_done}, 32'h0);
            end else begin
                checkOutput("wr_done", {31'h0, ls_done}, 32'h1);
                checkOutput("wr_strobe_end", {31'h0, mem_wr}, 32'h0);
            end
            if (k == rstc_at - 1) rst_c = 1'b1;
            if (k == rstc_at) rst_c = 1'b0;
            if (k == stall_at) begin
                rdy = 1'b0;
                #1;
                checkOutput("stall_wr_low", {31'h0, mem_wr}, 32'h0);
                for (int s = 0; s < 3; s++) begin
                    tick();
                    checkOutput("stall_wr_low", {31'h0, mem_wr}, 32'h0);
                    checkOutput("stall_addr_hold", mem_a, addr + k);
                end
                rdy = 1'b1;
                #1;
                checkOutput("stall_wr_resume", {31'h0, mem_wr}, 32'h1);
            end
        end
        ls_en = 1'b0;
        tick();
        checkOutput("wr_done_pulse", {31'h0, ls_done}, 32'h0);
        checkOutput("wr_ls_data_hold", ls_rdata, exp_ls_data);
        checkOutput("wr_count", wr_count - wc0, n);
        for (int i = 0; i < n; i++) begin
            ref_mem[addr + i] = data[8*i +: 8];
            checkOutput("wr_ram", {24'h0, ram_read(addr + i)}, {24'h0, data[8*i +: 8]});
        end
    endtask

    initial begin
        logic [31:0] a, d;
        int kind;
        rst = 1'b1; rst_c = 1'b0; rdy = 1'b1;
        if_en = 1'b0; if_addr = 32'h0;
        ls_en = 1'b0; ls_we = 1'b0; ls_addr = 32'h0; ls_len = 2'b00; ls_wdata = 32'h0;
        exp_if_data = 32'h0; exp_ls_data = 32'h0;
        repeat (3) tick();
        checkOutput("rst_done", {30'h0, if_done, ls_done}, 32'h0);
        checkOutput("rst_if_data", if_data, 32'h0);
        checkOutput("rst_ls_data", ls_rdata, 32'h0);
        checkOutput("rst_addr", mem_a, 32'h0);
        checkOutput("rst_wr", {31'h0, mem_wr}, 32'h0);
        checkOutput("rst_dout", {24'h0, mem_dout}, 32'h0);
        rst = 1'b0;

        // Contention right after reset: LS wins, IF follows the edge after ls_done
        if_en = 1'b1; if_addr = 32'h0;
        ls_en = 1'b1; ls_we = 1'b0; ls_addr = 32'h200; ls_len = 2'b01;
        for (int k = 0; k <= 9; k++) begin
            tick();
            if (k == 0) checkOutput("cont_ls_a0", mem_a, 32'h200);
            if (k == 1) checkOutput("cont_ls_a1", mem_a, 32'h201);
            if (k == 3) begin
                checkOutput("cont_ls_done", {31'h0, ls_done}, 32'h1);
                exp_ls_data = 32'h0000BBAA;
                checkOutput("cont_ls_data", ls_rdata, exp_ls_data);
                ls_en = 1'b0;
            end
            if (k >= 5 && k <= 7) checkOutput("cont_if_addr", mem_a, k - 4);
            if (k == 8) checkOutput("cont_if_early", {31'h0, if_done}, 32'h0);
            if (k == 9) begin
                checkOutput("cont_if_done", {31'h0, if_done}, 32'h1);
                exp_if_data = {ref_read(3), ref_read(2), ref_read(1), ref_read(0)};
                checkOutput("cont_if_data", if_data, exp_if_data);
                if_en = 1'b0;
            end
        end
        tick();

        applyRead(1'b1, 32'h100, 2'b00);
        checkOutput("fetch_0x100", if_data, 32'h44332211);

        // rst_c at E2 of a fetch aborts it
        if_en = 1'b1; if_addr = 32'h300;
        tick();
        checkOutput("flush_a0", mem_a, 32'h300);
        tick();
        rst_c = 1'b1;
        tick();
        rst_c = 1'b0; if_en = 1'b0;
        checkOutput("flush_idle", mem_a, 32'h0);
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput("flush_no_done", {31'h0, if_done}, 32'h0);
        end
        checkOutput("flush_data_hold", if_data, exp_if_data);

        // rst_c in IDLE blocks acceptance
        rst_c = 1'b1; if_en = 1'b1; if_addr = 32'h104;
        tick();
        checkOutput("rstc_block", mem_a, 32'h0);
        rst_c = 1'b0; if_en = 1'b0;
        tick();

        applyStimulus(32'h1000, 2'b10, 32'hDEADBEEF, -1, -1);
        applyStimulus(32'h2000, 2'b10, 32'hCAFEF00D, -1, 2);
        applyStimulus(32'hFFFFFFFE, 2'b11, 32'h76543210, 1, -1);
        applyRead(1'b0, 32'hFFFFFFFE, 2'b10);

        // Round robin: after an LS grant, simultaneous requests go to IF
        applyRead(1'b0, 32'h40, 2'b00);
        if_en = 1'b1; if_addr = 32'h100;
        ls_en = 1'b1; ls_we = 1'b0; ls_addr = 32'h200; ls_len = 2'b10;
        for (int k = 0; k <= 11; k++) begin
            tick();
            if (k == 0) checkOutput("rr_if_first", mem_a, 32'h100);
            if (k == 5) begin
                checkOutput("rr_if_done", {31'h0, if_done}, 32'h1);
                exp_if_data = 32'h44332211;
                checkOutput("rr_if_data", if_data, exp_if_data);
                if_en = 1'b0;
            end
            if (k == 6) checkOutput("rr_ls_start", mem_a, 32'h200);
            if (k == 11) begin
                checkOutput("rr_ls_done", {31'h0, ls_done}, 32'h1);
                exp_ls_data = {ref_read(32'h203), ref_read(32'h202), 8'hBB, 8'hAA};
                checkOutput("rr_ls_data", ls_rdata, exp_ls_data);
                ls_en = 1'b0;
            end
        end
        tick();

        // Random traffic against the reference memory
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 2);
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFFC + $urandom_range(0, 3);
            d = $urandom;
            case (kind)
                0: applyRead(1'b1, a, 2'b00);
                1: applyRead(1'b0, a, 2'($urandom_range(0, 3)));
                default: applyStimulus(a, 2'($urandom_range(0, 3)), d, -1, -1);
            endcase
        end

        // Reset during a store overrides rdy and rst_c
        d = 32'hA1B2C3D4;
        a = 32'h7000_0000;
        kind = wr_count;
        ls_en = 1'b1; ls_we = 1'b1; ls_addr = a; ls_len = 2'b10; ls_wdata = d;
        tick();
        tick();
        rst = 1'b1; rdy = 1'b0; rst_c = 1'b1;
        tick();
        checkOutput("rst_mid_addr", mem_a, 32'h0);
        checkOutput("rst_mid_done", {30'h0, if_done, ls_done}, 32'h0);
        checkOutput("rst_mid_ls_data", ls_rdata, 32'h0);
        checkOutput("rst_mid_if_data", if_data, 32'h0);
        rst = 1'b0; rdy = 1'b1; rst_c = 1'b0; ls_en = 1'b0;
        tick();
        checkOutput("rst_mid_wr", {31'h0, mem_wr}, 32'h0);
        checkOutput("rst_mid_wr_count", wr_count - kind, 32'h1);
        ref_mem[a] = d[7:0];
        exp_if_data = 32'h0;
        exp_ls_data = 32'h0;
        applyRead(1'b1, a, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have ports: clk input 1 (clock); rst input 1 (reset, synchronous, active-high); rst_c input 1 (pipeline flush, synchronous, active-high); rdy input 1 (global enable; low = freeze).
REQ-002 SHALL have fetch-side ports: if_en_i input 1 (fetch request, level); if_addr_i input 32 (word fetch address); if_done_o output 1 (one-cycle completion pulse); if_data_o output 32 (fetched word, little-endian).
REQ-003 SHALL have load/store-side ports: ls_en_i input 1 (request, level); ls_we_i input 1 (1 = store); ls_addr_i input 32 (byte address); ls_len_i input 2 (00=1B, 01=2B, 10=4B, 11 treated as 4B); ls_data_i input 32 (store data, byte 0 in [7:0]); ls_done_o output 1 (completion pulse); ls_data_o output 32 (raw load data, unextended).
REQ-004 SHALL have RAM ports: mem_a_o output 32 (byte address); mem_wr_o output 1 (write strobe); mem_dout_o output 8 (write byte); mem_din_i input 8 (read byte, valid the second edge after address driven).

Function
REQ-005 SHALL implement states IDLE and BUSY; a request is accepted only in IDLE, and only when the corresponding done output is low that cycle.
REQ-006 Requesters SHALL hold en_i and operands stable until their done pulse; operands SHALL be latched at acceptance.
REQ-007 When exactly one of if_en_i/ls_en_i is high in IDLE, that requester SHALL be granted at that edge.
REQ-008 When both are high in IDLE, grant SHALL go to the requester not granted last (round-robin); last_grant resets to IF, so LS wins the first contention.
REQ-009 Read of N bytes (IF always N=4): acceptance edge E0 drives mem_a_o=addr; edge Ek (k=1..N-1) drives mem_a_o=addr+k; mem_din_i sampled at E(i+2) into bits [8i+7:8i]; done pulse and full data register at E(N+1).
REQ-010 Unread upper bytes of ls_data_o SHALL be zero.
REQ-011 Write of N bytes: edge Ei (i=0..N-1) drives mem_a_o=addr+i, mem_dout_o=ls_data_i byte i, mem_wr_o=1; at EN mem_wr_o=0 and ls_done_o pulses.
REQ-012 Address increment SHALL be 32-bit modulo 2^32 (wrap from 0xFFFFFFFF to 0x0).
REQ-013 Done pulses SHALL last exactly one cycle; data outputs SHALL hold their value until the next completion of the same requester.
REQ-014 FSM SHALL return to IDLE at the done edge; the next acceptance occurs no earlier than the edge after done.
REQ-015 rst_c SHALL abort an in-progress IF or LS read: return to IDLE, no done pulse, mem_wr_o=0, last_grant unchanged.
REQ-016 rst_c SHALL NOT abort an in-progress LS write (committed store); it completes and pulses ls_done_o normally.
REQ-017 rst_c in IDLE SHALL block acceptance that cycle.
REQ-018 While rdy=0, all state, counters and outputs SHALL hold, except mem_wr_o which SHALL be forced 0 (mem_wr_o = wr_reg AND rdy).
REQ-019 In IDLE, mem_a_o SHALL be 0 and mem_wr_o 0.

Reset
REQ-020 On rst: state=IDLE, last_grant=IF, if_done_o=0, ls_done_o=0, if_data_o=0, ls_data_o=0, mem_a_o=0, mem_wr_o=0, mem_dout_o=0; rst overrides rst_c and rdy, including during an in-progress write.

Verification
REQ-021 IF fetch 0x100, RAM bytes 11,22,33,44 -> mem_a_o 0x100..0x103 on E0..E3, if_done_o pulse at E5, if_data_o=0x44332211.
REQ-022 Both requesters high after reset (IF 0x0, LS read 2B at 0x200) -> LS granted first; ls_data_o=0x0000BBAA at E3; IF accepted at edge after ls_done_o.
REQ-023 LS store 4B 0xDEADBEEF at 0x1000 -> mem_wr_o=1 for 4 cycles, bytes EF,BE,AD,DE at 0x1000..0x1003, ls_done_o at E4.
REQ-024 rst_c at E2 of IF fetch -> no if_done_o, IDLE next cycle; rst_c at E2 of 4B store -> all 4 bytes written, ls_done_o at E4.
REQ-025 rdy=0 for 3 cycles mid-store at 0xFFFFFFFE len 4 -> mem_wr_o=0 during stall, no duplicate/missed bytes, addresses 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1.
